updown_counter: RTL and testbench

Parameterised synchronous binary up/down counter with count enable, parallel load and a terminal-count flag. Default width is 4 bits. Used as a general-purpose event or position counter; the direction is selected every cycle by a single input. Single clock domain, asynchronous active-low reset.

---
 rtl/updown_counter_pkg.sv | 20 ++
 rtl/updown_counter_if.sv | 13 +
 rtl/updown_counter_next.sv | 53 +++++
 rtl/updown_counter.sv | 44 ++++
 tb/tb_updown_counter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/updown_counter_pkg.sv
// Shared types and helpers for the up/down counter.
// Optional build macro used by this design: UPDOWN_COUNTER_SATURATE_EN.
package updown_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int DEFAULT_WIDTH = 4;

    // All-ones value for a counter of the given width (width <= 32).
    function automatic logic [31:0] max_val(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/updown_counter_if.sv
// Signal bundle for the up/down counter; connects a bench to the top level.
interface updown_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             clk;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             tc;
endinterface

// File: rtl/updown_counter_next.sv
// Combinational next-count and terminal-count logic for the up/down counter.
// Define UPDOWN_COUNTER_SATURATE_EN to clamp at the limits instead of wrapping.
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_next,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dir_e w_dir;
    logic w_atMax;
    logic w_atZero;

    assign w_dir    = dir_e'(i_up);
    assign w_atMax  = (i_count == MAX);
    assign w_atZero = (i_count == '0);

    // tc marks that the next enabled count would cross (or sit on) a limit.
    assign o_tc = i_en & ~i_load &
                  (((w_dir == DIR_UP) & w_atMax) | ((w_dir == DIR_DOWN) & w_atZero));

    always_comb begin
        o_next = i_count;
        if (i_load) begin
            o_next = i_din;
        end else if (i_en) begin
            if (w_dir == DIR_UP) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                o_next = w_atMax ? i_count : i_count + ONE;
`else
                o_next = i_count + ONE;
`endif
            end else begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                o_next = w_atZero ? i_count : i_count - ONE;
`else
                o_next = i_count - ONE;
`endif
            end
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with enable, parallel load and terminal-count flag.
// Saturating behaviour is selected by UPDOWN_COUNTER_SATURATE_EN.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    updown_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_count (r_count),
        .i_en    (en),
        .i_up    (up),
        .i_load  (load),
        .i_din   (din),
        .o_next  (w_next),
        .o_tc    (tc)
    );

    // rst is active-low and clears the count without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign dout = r_count;

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (WIDTH=4).
// Build with UPDOWN_COUNTER_SATURATE_EN to exercise the saturating variant.
module tb_updown_counter;

    localparam int WIDTH = 4;

    updown_counter_if #(.WIDTH(WIDTH)) bus ();

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    updown_counter #(
        .WIDTH (WIDTH)
    ) dut (
        .clk  (bus.clk),
        .rst  (bus.rst),
        .en   (bus.en),
        .up   (bus.up),
        .load (bus.load),
        .din  (bus.din),
        .dout (bus.dout),
        .tc   (bus.tc)
    );

    initial bus.clk = 1'b0;
    always #5 bus.clk = ~bus.clk;

    // Drive inputs on the falling edge so they are stable at the next rising edge.
    task automatic applyStimulus(input logic l, input logic [WIDTH-1:0] d,
                                 input logic e, input logic u);
        @(negedge bus.clk);
        bus.load = l;
        bus.din  = d;
        bus.en   = e;
        bus.up   = u;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge bus.clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] expDout,
                               input logic expTc);
        checkCount++;
        assert (bus.dout === expDout) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s dout observed=%0d expected=%0d", tag, bus.dout, expDout);
        end
        checkCount++;
        assert (bus.tc === expTc) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s tc observed=%0b expected=%0b", tag, bus.tc, expTc);
        end
    endtask

    logic [WIDTH-1:0] model;
    logic             modelTc;
    logic             dirBit;

    initial begin
        bus.rst  = 1'b0;
        bus.en   = 1'b0;
        bus.up   = 1'b0;
        bus.load = 1'b0;
        bus.din  = '0;

        // Reset held for three cycles while en/up wiggle; tc = en & ~up at dout=0.
        for (int i = 0; i < 3; i++) begin
            @(negedge bus.clk);
            bus.en = 1'b1;
            bus.up = logic'(i % 2);
            #1;
            checkOutput("reset_pre", 4'd0, ~bus.up);
            @(posedge bus.clk);
            #1;
            checkOutput("reset_post", 4'd0, ~bus.up);
        end
        @(negedge bus.clk);
        bus.rst = 1'b1;
        bus.en  = 1'b1;
        bus.up  = 1'b1;
        clockEdge();
        checkOutput("reset_release", 4'd1, 1'b0);

`ifndef UPDOWN_COUNTER_SATURATE_EN
        // Up wrap 14 -> 15 -> 0 -> 1.
        applyStimulus(1'b1, 4'd14, 1'b0, 1'b1);
        clockEdge();
        checkOutput("upwrap_load", 4'd14, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("upwrap_14", 4'd14, 1'b0);
        clockEdge();
        checkOutput("upwrap_15", 4'd15, 1'b1);
        clockEdge();
        checkOutput("upwrap_0", 4'd0, 1'b0);
        clockEdge();
        checkOutput("upwrap_1", 4'd1, 1'b0);

        // Down wrap 1 -> 0 -> 15 -> 14.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        clockEdge();
        checkOutput("dnwrap_load", 4'd1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("dnwrap_1", 4'd1, 1'b0);
        clockEdge();
        checkOutput("dnwrap_0", 4'd0, 1'b1);
        clockEdge();
        checkOutput("dnwrap_15", 4'd15, 1'b0);
        clockEdge();
        checkOutput("dnwrap_14", 4'd14, 1'b0);
`else
        // Saturation at both limits; tc stays high while pinned.
        applyStimulus(1'b1, 4'd15, 1'b0, 1'b1);
        clockEdge();
        checkOutput("sat_load15", 4'd15, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            clockEdge();
            checkOutput("sat_up", 4'd15, 1'b1);
        end
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        clockEdge();
        checkOutput("sat_load0", 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            clockEdge();
            checkOutput("sat_down", 4'd0, 1'b1);
        end
`endif

        // Load beats count, then hold with en=0.
        applyStimulus(1'b1, 4'd9, 1'b1, 1'b1);
        clockEdge();
        checkOutput("prio_load", 4'd9, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            clockEdge();
            checkOutput("hold", 4'd9, 1'b0);
        end

        // Load at MAX masks tc; it appears once load drops.
        applyStimulus(1'b1, 4'd15, 1'b1, 1'b1);
        clockEdge();
        checkOutput("tc_masked", 4'd15, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("tc_unmasked", 4'd15, 1'b1);

        // Count to 7, then assert reset between edges.
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
        clockEdge();
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            clockEdge();
        end
        checkOutput("count7", 4'd7, 1'b0);
        #2;
        bus.rst = 1'b0;
        bus.en  = 1'b0;
        #1;
        checkOutput("async_reset", 4'd0, 1'b0);
        @(negedge bus.clk);
        bus.rst = 1'b1;

        // Random direction for 20 cycles against a reference model.
        model = '0;
        for (int i = 0; i < 20; i++) begin
            dirBit = logic'($urandom_range(0, 1));
            applyStimulus(1'b0, 4'd0, 1'b1, dirBit);
            modelTc = dirBit ? (model == 4'd15) : (model == 4'd0);
            checkOutput("rand_pre", model, modelTc);
`ifdef UPDOWN_COUNTER_SATURATE_EN
            if (dirBit && model != 4'd15) model = model + 4'd1;
            else if (!dirBit && model != 4'd0) model = model - 4'd1;
`else
            model = dirBit ? model + 4'd1 : model - 4'd1;
`endif
            clockEdge();
            modelTc = dirBit ? (model == 4'd15) : (model == 4'd0);
            checkOutput("rand_post", model, modelTc);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
